// File: rtl/colorspace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : colorspace_pkg
// Description : Shared types and helpers for the colorspace datapath.
//               - state_t        : FSM encoding used by the multiply_acc unit
//               - MUL_STEP_BITS  : multiplier bits consumed per RUN iteration
//               - clog2()        : ceiling log2 for constant sizing
//               - mul_latency()  : RUN cycles of multiply_acc for a width
//               Build option MULTIPLY_ACC_RADIX4_EN selects two multiplier
//               bits per iteration instead of one.
// Revision    : 1.0 - initial release
// ============================================================================
package colorspace_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

`ifdef MULTIPLY_ACC_RADIX4_EN
   localparam int MUL_STEP_BITS = 2;
`else
   localparam int MUL_STEP_BITS = 1;
`endif

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Radix-2 needs one iteration per operand bit; radix-4 needs ceil(W/2).
   function automatic int mul_latency(input int width);
      return (width + MUL_STEP_BITS - 1) / MUL_STEP_BITS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multiply_acc_step.sv
`default_nettype none
// ============================================================================
// Module      : multiply_acc_step
// Description : One combinational shift-add iteration of multiply_acc.
//               Adds the selected multiple of the (pre-shifted) multiplicand
//               to the accumulator according to the low multiplier bit(s).
//               Build option MULTIPLY_ACC_RADIX4_EN: two multiplier bits,
//               adding 0, A, 2A or 3A (3A supplied precomputed).
// Ports       : i_acc      accumulator in            (2*WIDTH)
//               i_a        shifted multiplicand      (2*WIDTH)
//               i_a3       shifted 3x multiplicand   (2*WIDTH+2, radix-4 only)
//               i_b_lsb    multiplier low bit(s)     (MUL_STEP_BITS)
//               o_acc_next accumulator out           (2*WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module multiply_acc_step
   import colorspace_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0]     i_acc,
   input  logic [2*WIDTH-1:0]     i_a,
`ifdef MULTIPLY_ACC_RADIX4_EN
   input  logic [2*WIDTH+1:0]     i_a3,
`endif
   input  logic [MUL_STEP_BITS-1:0] i_b_lsb,
   output logic [2*WIDTH-1:0]     o_acc_next
);

`ifdef MULTIPLY_ACC_RADIX4_EN
   // The final sum always fits in 2*WIDTH bits, so any partial term can be
   // taken modulo 2^(2*WIDTH); the two guard bits of 3A are never needed.
   logic w_unused_a3;
   assign w_unused_a3 = ^i_a3[2*WIDTH+1:2*WIDTH];

   always_comb begin
      o_acc_next = i_acc;
      case (i_b_lsb)
         2'd1:    o_acc_next = i_acc + i_a;
         2'd2:    o_acc_next = i_acc + (i_a << 1);
         2'd3:    o_acc_next = i_acc + i_a3[2*WIDTH-1:0];
         default: o_acc_next = i_acc;
      endcase
   end
`else
   assign o_acc_next = i_b_lsb[0] ? (i_acc + i_a) : i_acc;
`endif

endmodule
`default_nettype wire

// File: rtl/multiply_acc.sv
`default_nettype none
// ============================================================================
// Module      : multiply_acc
// Description : Sequential unsigned multiply-accumulate, o_p = A*B + C.
//               Start/done handshake, fixed latency of mul_latency(WIDTH)
//               RUN cycles, result held until the next accept.
//               Build option MULTIPLY_ACC_RADIX4_EN halves the latency by
//               retiring two multiplier bits per cycle.
// Ports       : i_clk     clock, rising edge
//               i_nreset  asynchronous active-low reset
//               i_start   start request, accepted in IDLE or DONE
//               i_a/i_b/i_c  multiplicand / multiplier / addend (WIDTH)
//               o_busy    operation in progress
//               o_done    one-cycle pulse when o_p is updated
//               o_p       result (2*WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module multiply_acc
   import colorspace_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_nreset,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   input  logic [WIDTH-1:0]     i_c,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_p
);

   localparam int c_lat = mul_latency(WIDTH);
   localparam int c_cw  = clog2(WIDTH + 1);
   // Multiplier register rounded up to whole iterations (odd WIDTH in
   // radix-4 gets one zero bit on top).
   localparam int c_bw  = MUL_STEP_BITS * c_lat;
   localparam logic [c_cw-1:0] c_cnt_load = c_cw'(c_lat);
   localparam logic [c_cw-1:0] c_cnt_last = c_cw'(1);

   state_t                r_state;
   logic [2*WIDTH-1:0]    r_a;
   logic [c_bw-1:0]       r_b;
   logic [2*WIDTH-1:0]    r_acc;
   logic [c_cw-1:0]       r_cnt;
   logic [2*WIDTH-1:0]    r_p;
   logic                  r_busy;
   logic                  r_done;
`ifdef MULTIPLY_ACC_RADIX4_EN
   logic [2*WIDTH+1:0]    r_a3;
`endif

   logic [2*WIDTH-1:0]    w_acc_next;
   logic [2*WIDTH-1:0]    w_a_ext;

   assign w_a_ext = {{WIDTH{1'b0}}, i_a};

   multiply_acc_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_acc      (r_acc),
      .i_a        (r_a),
`ifdef MULTIPLY_ACC_RADIX4_EN
      .i_a3       (r_a3),
`endif
      .i_b_lsb    (r_b[MUL_STEP_BITS-1:0]),
      .o_acc_next (w_acc_next)
   );

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef MULTIPLY_ACC_RADIX4_EN
         r_a3    <= '0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_a     <= w_a_ext;
                  r_b     <= c_bw'(i_b);
                  r_acc   <= {{WIDTH{1'b0}}, i_c};
                  r_cnt   <= c_cnt_load;
`ifdef MULTIPLY_ACC_RADIX4_EN
                  r_a3    <= ({2'b00, w_a_ext} << 1) + {2'b00, w_a_ext};
`endif
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_acc <= w_acc_next;
               r_a   <= r_a << MUL_STEP_BITS;
               r_b   <= r_b >> MUL_STEP_BITS;
               r_cnt <= r_cnt - 1'b1;
`ifdef MULTIPLY_ACC_RADIX4_EN
               r_a3  <= r_a3 << MUL_STEP_BITS;
`endif
               // Final iteration: publish the sum including this step.
               if (r_cnt == c_cnt_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_p     <= w_acc_next;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_multiply_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiply_acc
// Description : Self-checking bench for multiply_acc (WIDTH=8). Results are
//               compared with plain A*B+C arithmetic and the handshake with
//               the expected fixed latency from mul_latency().
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiply_acc;
   import colorspace_pkg::*;

   localparam int W = 8;
   localparam int L = mul_latency(W);

   logic           clk    = 1'b0;
   logic           nreset = 1'b0;
   logic           start  = 1'b0;
   logic [W-1:0]   a      = '0;
   logic [W-1:0]   b      = '0;
   logic [W-1:0]   c      = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;

   int checks = 0;
   int errors = 0;

   multiply_acc #(.WIDTH(W)) dut (
      .i_clk    (clk),
      .i_nreset (nreset),
      .i_start  (start),
      .i_a      (a),
      .i_b      (b),
      .i_c      (c),
      .o_busy   (busy),
      .o_done   (done),
      .o_p      (p)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (time %0t, limit 1000000)", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] z);
      logic [63:0] r;
      r = 64'(x) * 64'(y) + 64'(z);
      return r[2*W-1:0];
   endfunction

   // Issue one operation from a falling edge and follow it to o_done.
   // Operand inputs are scrambled after accept to prove they were latched.
   task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] xc,
                        output int lat, output logic [2*W-1:0] res, output bit busy_ok);
      lat = -1; res = '0; busy_ok = 1'b1;
      a = xa; b = xb; c = xc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      if (!busy) busy_ok = 1'b0;
      for (int n = 1; n <= 4*W + 4; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n; res = p;
            if (busy) busy_ok = 1'b0;
            break;
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (p !== '0) begin errors++; $display("FAIL reset_p: got %0d want 0", p); end
      nreset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int lat; logic [2*W-1:0] res; bit bok;
      do_op(8'd13, 8'd11, 8'd5, lat, res, bok);
      checks++; if (lat !== L) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, L); end
      checks++; if (res !== 16'd148) begin errors++; $display("FAIL basic_p: got %0d want 148", res); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy: busy window wrong (got %b want 1)", bok); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      checks++; if (p !== 16'd148) begin errors++; $display("FAIL basic_p_hold: got %0d want 148", p); end
   endtask

   task automatic test_max();
      int lat; logic [2*W-1:0] res; bit bok;
      do_op(8'd255, 8'd255, 8'd255, lat, res, bok);
      checks++; if (res !== 16'd65280) begin errors++; $display("FAIL max_p: got %0d want 65280", res); end
      checks++; if (lat !== L) begin errors++; $display("FAIL max_latency: got %0d want %0d", lat, L); end
      do_op(8'd0, 8'd200, 8'd7, lat, res, bok);
      checks++; if (res !== 16'd7) begin errors++; $display("FAIL zero_p: got %0d want 7", res); end
      checks++; if (lat !== L) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, L); end
   endtask

   task automatic test_random();
      int lat; logic [2*W-1:0] res; bit bok;
      logic [W-1:0] xa, xb, xc;
      for (int i = 0; i < 30; i++) begin
         xa = W'($urandom); xb = W'($urandom); xc = W'($urandom);
         do_op(xa, xb, xc, lat, res, bok);
         checks++; if (res !== ref_mac(xa, xb, xc)) begin
            errors++; $display("FAIL random_p: %0d*%0d+%0d got %0d want %0d", xa, xb, xc, res, ref_mac(xa, xb, xc));
         end
         checks++; if (lat !== L || bok !== 1'b1) begin
            errors++; $display("FAIL random_timing: got lat=%0d busy_ok=%b want lat=%0d busy_ok=1", lat, bok, L);
         end
      end
   endtask

   task automatic test_roundtrip();
      int lat; logic [2*W-1:0] res; bit bok;
      int na, nb;
      for (int i = 0; i < 120; i++) begin
         na = int'($urandom_range(255, 1));
         nb = int'($urandom_range(255, 1));
         do_op(W'(na / nb), W'(nb), W'(na % nb), lat, res, bok);
         checks++; if (res !== 16'(na)) begin
            errors++; $display("FAIL roundtrip: A=%0d B=%0d got %0d want %0d", na, nb, res, na);
         end
      end
   endtask

   task automatic test_start_busy();
      int lat; int extra;
      logic [W-1:0] xa, xb, xc;
      xa = W'($urandom); xb = W'($urandom); xc = W'($urandom);
      a = xa; b = xb; c = xc; start = 1'b1;
      @(negedge clk);                      // after accept edge k
      start = 1'b0;
      @(negedge clk);                      // after k+1
      @(negedge clk);                      // after k+2
      a = ~xa; b = ~xb; c = ~xc; start = 1'b1;
      @(negedge clk);                      // after k+3, the pulse was seen in RUN
      start = 1'b0;
      lat = -1;
      for (int n = 4; n <= 4*W; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
      end
      checks++; if (lat !== L) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, L); end
      checks++; if (p !== ref_mac(xa, xb, xc)) begin
         errors++; $display("FAIL busy_start_p: got %0d want %0d", p, ref_mac(xa, xb, xc));
      end
      extra = 0;
      for (int n = 0; n < L + 3; n++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_second: got %0d extra active cycles want 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] q[$];
      logic [2*W-1:0] exp_p;
      bit exp_done;
      localparam int R = 5;
      a = W'($urandom); b = W'($urandom); c = W'($urandom); start = 1'b1;
      for (int t = 0; t < R*(L+1); t++) begin
         @(negedge clk);                   // after edge t; accepts at t = 0, L+1, ...
         if (t % (L+1) == 0) begin
            q.push_back(ref_mac(a, b, c));
            if (t / (L+1) == R-1) start = 1'b0;
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
         end
         exp_done = (t % (L+1) == L);
         checks++; if (done !== exp_done || busy !== !exp_done) begin
            errors++; $display("FAIL b2b_handshake t=%0d: got done=%b busy=%b want done=%b busy=%b",
                               t, done, busy, exp_done, !exp_done);
         end
         if (exp_done) begin
            exp_p = q.pop_front();
            checks++; if (p !== exp_p) begin errors++; $display("FAIL b2b_p t=%0d: got %0d want %0d", t, p, exp_p); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [2*W-1:0] res; bit bok; int seen;
      do_op(8'd100, 8'd100, 8'd1, lat, res, bok);   // leave a nonzero result on o_p
      a = 8'd77; b = 8'd99; c = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 nreset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
         errors++; $display("FAIL async_reset: got busy=%b done=%b p=%0d want 0 0 0", busy, done, p);
      end
      @(negedge clk);
      nreset = 1'b1;
      seen = 0;
      for (int n = 0; n < 2*L + 4; n++) begin
         @(negedge clk);
         if (done || busy || p !== '0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL reset_quiet: got %0d active cycles want 0", seen); end
      do_op(8'd21, 8'd12, 8'd9, lat, res, bok);
      checks++; if (res !== ref_mac(8'd21, 8'd12, 8'd9) || lat !== L) begin
         errors++; $display("FAIL reset_recover: got p=%0d lat=%0d want p=%0d lat=%0d", res, lat, ref_mac(8'd21, 8'd12, 8'd9), L);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_max();
      test_random();
      test_roundtrip();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
